mac_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate unit that supersedes the single-mode 8-bit MAC. It accepts one operand pair per cycle under a valid strobe and supports signed and unsigned products. Overflow is handled by wrap or saturation, with a sticky flag. The block accumulates fixed-length windows of LEN products and emits each finished dot product with a one-cycle valid pulse. It sits between the operand streamers and the result collector in the compute datapath.

---
 rtl/mac_pipe.sv | 115 +++++++++++
 tb/tb_mac_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe.sv
// Two-stage pipelined multiply-accumulate unit: registered product, then windowed
// accumulation over LEN products with wrap/saturate overflow handling.
module mac_pipe #(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             signed_mode,
  input  logic             sat_mode,
  output logic [ACC_W-1:0] acc,
  output logic             of,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_of
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic [2*W-1:0]   r_p;
  logic             r_p_valid;
  logic             r_p_signed;
  logic             r_p_sat;
  logic [CNT_W-1:0] r_cnt;

  logic [2*W-1:0]   w_prod;
  logic             w_load;
  logic [ACC_W-1:0] w_p_ext;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_of_next;

  // Stage 1 product: operands widened to 2W first so the low 2W bits are exact.
  always_comb begin
    w_prod = '0;
    if (signed_mode)
      w_prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    else
      w_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  end

  // Window start adds to zero, which can never overflow, so no special-casing is needed.
  always_comb begin
    w_load     = (r_cnt == '0);
    w_p_ext    = r_p_signed ? ACC_W'($signed(r_p)) : ACC_W'(r_p);
    w_base     = w_load ? '0 : acc;
    w_sum      = {1'b0, w_base} + {1'b0, w_p_ext};
    w_ovf      = 1'b0;
    w_acc_next = w_sum[ACC_W-1:0];
    if (r_p_signed)
      w_ovf = (w_base[ACC_W-1] == w_p_ext[ACC_W-1]) &&
              (w_sum[ACC_W-1] != w_base[ACC_W-1]);
    else
      w_ovf = w_sum[ACC_W];
    if (w_ovf && r_p_sat) begin
      if (!r_p_signed)
        w_acc_next = '1;
      else if (w_p_ext[ACC_W-1])
        w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      else
        w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
    w_of_next = (w_load ? 1'b0 : of) | w_ovf;
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_p        <= '0;
      r_p_valid  <= 1'b0;
      r_p_signed <= 1'b0;
      r_p_sat    <= 1'b0;
      r_cnt      <= '0;
      acc        <= '0;
      of         <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_of     <= 1'b0;
    end else if (clr) begin
      r_p_valid <= 1'b0;
      r_cnt     <= '0;
      acc       <= '0;
      of        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      r_p_valid <= in_valid;
      if (in_valid) begin
        r_p        <= w_prod;
        r_p_signed <= signed_mode;
        r_p_sat    <= sat_mode;
      end
      out_valid <= 1'b0;
      if (r_p_valid) begin
        acc <= w_acc_next;
        of  <= w_of_next;
        if (r_cnt == CNT_LAST) begin
          r_cnt     <= '0;
          out_valid <= 1'b1;
          out_acc   <= w_acc_next;
          out_of    <= w_of_next;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe: LEN=4 and LEN=1 instances share stimulus; an
// arithmetic reference model queues expected acc/window results for a negedge monitor.
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        r, clr, in_valid, signed_mode, sat_mode;
  logic [7:0]  a, b;
  logic [15:0] acc0, out_acc0, acc1, out_acc1;
  logic        of0, out_valid0, out_of0, of1, out_valid1, out_of1;

  mac_pipe #(.W(8), .ACC_W(16), .LEN(4)) u_dut (
    .clk(clk), .r(r), .clr(clr), .in_valid(in_valid), .a(a), .b(b),
    .signed_mode(signed_mode), .sat_mode(sat_mode),
    .acc(acc0), .of(of0), .out_valid(out_valid0), .out_acc(out_acc0), .out_of(out_of0)
  );

  mac_pipe #(.W(8), .ACC_W(16), .LEN(1)) u_dut_len1 (
    .clk(clk), .r(r), .clr(clr), .in_valid(in_valid), .a(a), .b(b),
    .signed_mode(signed_mode), .sat_mode(sat_mode),
    .acc(acc1), .of(of1), .out_valid(out_valid1), .out_acc(out_acc1), .out_of(out_of1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] v;
    logic        f;
  } exp_t;

  exp_t        qa[2][$];
  exp_t        qo[2][$];
  int          lens[2] = '{4, 1};
  logic [15:0] m_acc[2];
  logic        m_of[2];
  int          m_cnt[2];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  logic        last_iv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int k, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, got, want);
    end
  endfunction

  function automatic void push(ref exp_t q[$], input int due, input logic [15:0] v, input logic f);
    exp_t e;
    e.due = due;
    e.v   = v;
    e.f   = f;
    q.push_back(e);
  endfunction

  // Reference: plain integer arithmetic with range checks against the ACC_W interpretation.
  function automatic void model_pair(int k, logic [7:0] av, logic [7:0] bv,
                                     logic sm, logic sat, int due);
    longint p, cur, s, lo, hi;
    logic   ov;
    if (sm) p = longint'($signed(av)) * longint'($signed(bv));
    else    p = longint'(av) * longint'(bv);
    ov = 1'b0;
    if (m_cnt[k] == 0) begin
      s       = p;
      m_of[k] = 1'b0;
    end else begin
      if (sm) begin
        cur = longint'($signed(m_acc[k]));
        lo  = -32768;
        hi  = 32767;
      end else begin
        cur = longint'(m_acc[k]);
        lo  = 0;
        hi  = 65535;
      end
      s  = cur + p;
      ov = (s < lo) || (s > hi);
      if (ov && sat) s = (s > hi) ? hi : lo;
    end
    m_acc[k] = s[15:0];
    m_of[k]  = m_of[k] | ov;
    m_cnt[k]++;
    if (m_cnt[k] == lens[k]) begin
      m_cnt[k] = 0;
      push(qo[k], due, m_acc[k], m_of[k]);
    end
    push(qa[k], due, m_acc[k], m_of[k]);
  endfunction

  function automatic void model_clear(int k, int due);
    m_acc[k] = '0;
    m_of[k]  = 1'b0;
    m_cnt[k] = 0;
    push(qa[k], due, '0, 1'b0);
  endfunction

  task automatic mon(int k, logic [15:0] av, logic ofv, logic ov, logic [15:0] oav, logic oofv);
    exp_t e;
    logic want;
    while (qa[k].size() > 0 && qa[k][0].due <= cyc) begin
      e = qa[k].pop_front();
      chk("acc", k, 32'(av), 32'(e.v));
      chk("of", k, 32'(ofv), 32'(e.f));
    end
    want = (qo[k].size() > 0) && (qo[k][0].due == cyc);
    chk("out_valid", k, 32'(ov), 32'(want));
    if (qo[k].size() > 0 && qo[k][0].due <= cyc) begin
      e = qo[k].pop_front();
      if (want) begin
        chk("out_acc", k, 32'(oav), 32'(e.v));
        chk("out_of", k, 32'(oofv), 32'(e.f));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, acc0, of0, out_valid0, out_acc0, out_of0);
    mon(1, acc1, of1, out_valid1, out_acc1, out_of1);
  end

  task automatic step(logic iv, logic [7:0] av, logic [7:0] bv, logic sm, logic sat, logic c);
    @(posedge clk);
    #1;
    in_valid    = iv;
    a           = av;
    b           = bv;
    signed_mode = sm;
    sat_mode    = sat;
    clr         = c;
    for (int k = 0; k < 2; k++) begin
      if (c)       model_clear(k, cyc + 1);
      else if (iv) model_pair(k, av, bv, sm, sat, cyc + 2);
    end
    last_iv = iv && !c;
  endtask

  // A clr is kept one idle cycle away from the last pair so no product is in flight.
  task automatic drive(logic iv, logic [7:0] av, logic [7:0] bv, logic sm, logic sat, logic c);
    if (c && last_iv) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(iv, av, bv, sm, sat, c);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pair(logic [7:0] av, logic [7:0] bv, logic sm, logic sat);
    drive(1'b1, av, bv, sm, sat, 1'b0);
  endtask

  task automatic do_clr();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset_zero();
    chk("rst_acc", 0, 32'(acc0), 0);       chk("rst_acc", 1, 32'(acc1), 0);
    chk("rst_of", 0, 32'(of0), 0);         chk("rst_of", 1, 32'(of1), 0);
    chk("rst_out_valid", 0, 32'(out_valid0), 0);
    chk("rst_out_acc", 0, 32'(out_acc0), 0); chk("rst_out_acc", 1, 32'(out_acc1), 0);
    chk("rst_out_of", 0, 32'(out_of0), 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = '0;
      m_of[k]  = 1'b0;
      m_cnt[k] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    logic       riv, rc;
    r = 1'b0; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; sat_mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_zero();
    r = 1'b1;

    // unsigned wrap window
    pair(8'd6, 8'd9, 0, 0); pair(8'd5, 8'd4, 0, 0);
    pair(8'd9, 8'd2, 0, 0); pair(8'd3, 8'd8, 0, 0);
    idle(3);
    chk("win1_out_acc", 0, 32'(out_acc0), 116);
    chk("win1_out_of", 0, 32'(out_of0), 0);

    // unsigned overflow, wrap then saturate
    do_clr();
    pair(8'd255, 8'd255, 0, 0); pair(8'd40, 8'd40, 0, 0);
    idle(3);
    chk("wrap_acc", 0, 32'(acc0), 1089);
    chk("wrap_of", 0, 32'(of0), 1);
    do_clr();
    pair(8'd255, 8'd255, 0, 1); pair(8'd40, 8'd40, 0, 1);
    idle(3);
    chk("usat_acc", 0, 32'(acc0), 65535);
    chk("usat_of", 0, 32'(of0), 1);

    // signed saturate, then fresh negative product
    do_clr();
    pair(8'h80, 8'h80, 1, 1); pair(8'h80, 8'h80, 1, 1);
    idle(3);
    chk("ssat_acc", 0, 32'(acc0), 32767);
    chk("ssat_of", 0, 32'(of0), 1);
    do_clr();
    pair(8'hFD, 8'h05, 1, 1);
    idle(3);
    chk("sneg_acc", 0, 32'(acc0), 16'hFFF1);
    chk("sneg_of", 0, 32'(of0), 0);

    // back-to-back windows
    do_clr();
    repeat (8) pair(8'd1, 8'd1, 0, 0);
    idle(3);
    chk("b2b_out_acc", 0, 32'(out_acc0), 4);

    // reset mid-window
    do_clr();
    repeat (2) pair(8'd2, 8'd3, 0, 0);
    idle(2);
    @(posedge clk);
    #1;
    r = 1'b0;
    #2;
    chk_reset_zero();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_zero();
    r = 1'b1;
    repeat (4) pair(8'd2, 8'd3, 0, 0);
    idle(3);
    chk("rst_win_out_acc", 0, 32'(out_acc0), 24);

    // clr together with in_valid drops the pair; out_acc is retained
    drive(1'b1, 8'd50, 8'd50, 0, 0, 1'b1);
    idle(1);
    chk("clr_keep_out_acc", 0, 32'(out_acc0), 24);
    repeat (4) pair(8'd2, 8'd2, 0, 0);
    idle(3);
    chk("clr_win_out_acc", 0, 32'(out_acc0), 16);

    // gapped input
    repeat (4) begin
      pair(8'd7, 8'd9, 0, 0);
      idle(3);
    end
    chk("gap_out_acc", 0, 32'(out_acc0), 252);

    // randomized traffic with mid-window mode changes and occasional clr
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: ra = 8'($urandom);
        1: ra = 8'hFF;
        2: ra = 8'h80;
        default: ra = 8'h7F;
      endcase
      case ($urandom_range(3))
        0: rb = 8'($urandom);
        1: rb = 8'hFF;
        2: rb = 8'h80;
        default: rb = 8'h7F;
      endcase
      riv = ($urandom_range(3) != 0);
      rc  = ($urandom_range(29) == 0);
      drive(riv, ra, rb, 1'($urandom), 1'($urandom), rc);
    end

    idle(5);
    for (int k = 0; k < 2; k++) begin
      chk("drain_acc_q", k, 32'(qa[k].size()), 0);
      chk("drain_out_q", k, 32'(qo[k].size()), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
